reorder_buffer_mp: RTL and testbench

// Parametrised reorder buffer: in-order allocation from decoder, out-of-order completion over
// CDB_PORTS result buses, in-order single-entry commit to regfile/LSB/predictor. Adds occupancy

---
 rtl/reorder_buffer_mp.sv | 210 +++++++++++++++++++++
 tb/tb_reorder_buffer_mp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mp.sv
// Reorder buffer: in-order allocate, out-of-order completion over CDB_PORTS result buses,
// in-order single-entry commit with store release, branch resolve and mispredict flush.
module reorder_buffer_mp #(
    parameter int DEPTH = 8,
    parameter int CDB_PORTS = 2,
    localparam int TAG_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       iss_valid,
    input  logic [1:0]                 iss_type,
    input  logic [4:0]                 iss_rd,
    input  logic [31:0]                iss_pc,
    input  logic                       iss_pred_taken,
    input  logic [31:0]                iss_target,
    output logic [TAG_W-1:0]           iss_tag,
    output logic                       rob_full,
    output logic                       rob_empty,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*32-1:0]    cdb_val,
    input  logic [TAG_W-1:0]           q_tag1,
    input  logic [TAG_W-1:0]           q_tag2,
    output logic                       q_rdy1,
    output logic                       q_rdy2,
    output logic [31:0]                q_val1,
    output logic [31:0]                q_val2,
    output logic                       commit_valid,
    output logic [4:0]                 commit_rd,
    output logic [31:0]                commit_val,
    output logic [TAG_W-1:0]           commit_tag,
    output logic                       st_commit,
    output logic [TAG_W-1:0]           st_commit_tag,
    output logic                       bp_update,
    output logic [31:0]                bp_pc,
    output logic                       bp_taken,
    output logic                       flush_out,
    output logic [31:0]                flush_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] T_REG = 2'd0, T_BR = 2'd1, T_ST = 2'd2, T_JMP = 2'd3;

    logic        busy_q[DEPTH], busy_d[DEPTH], ready_q[DEPTH], ready_d[DEPTH];
    logic        pred_q[DEPTH], pred_d[DEPTH];
    logic [1:0]  type_q[DEPTH], type_d[DEPTH];
    logic [4:0]  rd_q[DEPTH], rd_d[DEPTH];
    logic [31:0] pc_q[DEPTH], pc_d[DEPTH], target_q[DEPTH], target_d[DEPTH];
    logic [31:0] res_q[DEPTH], res_d[DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;

    logic             commit_valid_q, commit_valid_d, st_commit_q, st_commit_d;
    logic             bp_update_q, bp_update_d, bp_taken_q, bp_taken_d, flush_q, flush_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_val_q, commit_val_d, bp_pc_q, bp_pc_d, flush_pc_q, flush_pc_d;
    logic [TAG_W-1:0] commit_tag_q, commit_tag_d, st_commit_tag_q, st_commit_tag_d;

    logic             issue_ok, retire, mispredict;
    logic [TAG_W-1:0] cdb_t, head_tag;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_W'(DEPTH));
    endfunction

    function automatic logic [PTR_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] m;
        m = t - TAG_W'(1);
        return m[PTR_W-1:0];
    endfunction

    // Operand lookup: CDB broadcast this cycle beats the stored result, lowest port first.
    function automatic logic [32:0] lookup(input logic [TAG_W-1:0] qt);
        logic [32:0] r;
        r = '0;
        if (qt == '0) begin
            r = {1'b1, 32'h0};
        end else begin
            if (tag_ok(qt)) r = {ready_q[tag_idx(qt)], res_q[tag_idx(qt)]};
            for (int p = CDB_PORTS - 1; p >= 0; p--)
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == qt)
                    r = {1'b1, cdb_val[p*32 +: 32]};
        end
        return r;
    endfunction

    assign {q_rdy1, q_val1} = lookup(q_tag1);
    assign {q_rdy2, q_val2} = lookup(q_tag2);

    assign rob_full  = (count_q == TAG_W'(DEPTH));
    assign rob_empty = (count_q == '0);
    assign iss_tag   = TAG_W'(tail_q) + TAG_W'(1);

    always_comb begin
        busy_d = busy_q;  ready_d = ready_q;  pred_d = pred_q;  type_d = type_q;
        rd_d = rd_q;  pc_d = pc_q;  target_d = target_q;  res_d = res_q;
        head_d = head_q;  tail_d = tail_q;  count_d = count_q;
        commit_valid_d = 1'b0;  st_commit_d = 1'b0;  bp_update_d = 1'b0;  flush_d = 1'b0;
        commit_rd_d = commit_rd_q;  commit_val_d = commit_val_q;  commit_tag_d = commit_tag_q;
        st_commit_tag_d = st_commit_tag_q;  bp_pc_d = bp_pc_q;  bp_taken_d = bp_taken_q;
        flush_pc_d = flush_pc_q;
        cdb_t = '0;
        retire = 1'b0;
        mispredict = 1'b0;
        head_tag = TAG_W'(head_q) + TAG_W'(1);
        issue_ok = iss_valid && rdy_in && !rob_full && !flush_q;

        if (rdy_in) begin
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                cdb_t = cdb_tag[p*TAG_W +: TAG_W];
                if (cdb_valid[p] && tag_ok(cdb_t) && busy_q[tag_idx(cdb_t)]) begin
                    ready_d[tag_idx(cdb_t)] = 1'b1;
                    res_d[tag_idx(cdb_t)]   = cdb_val[p*32 +: 32];
                end
            end

            retire = busy_q[head_q] && ready_q[head_q];
            if (retire) begin
                case (type_q[head_q])
                    T_REG, T_JMP: begin
                        commit_valid_d = (rd_q[head_q] != 5'd0);
                        commit_rd_d    = rd_q[head_q];
                        commit_val_d   = res_q[head_q];
                        commit_tag_d   = head_tag;
                    end
                    T_ST: begin
                        st_commit_d     = 1'b1;
                        st_commit_tag_d = head_tag;
                    end
                    default: begin
                        bp_update_d = 1'b1;
                        bp_pc_d     = pc_q[head_q];
                        bp_taken_d  = res_q[head_q][0];
                        if (res_q[head_q][0] != pred_q[head_q]) begin
                            mispredict = 1'b1;
                            flush_d    = 1'b1;
                            flush_pc_d = res_q[head_q][0] ? target_q[head_q]
                                                          : pc_q[head_q] + 32'd4;
                        end
                    end
                endcase
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d = head_q + PTR_W'(1);
            end

            if (issue_ok) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = 1'b0;
                res_d[tail_q]    = 32'h0;
                type_d[tail_q]   = iss_type;
                rd_d[tail_q]     = iss_rd;
                pc_d[tail_q]     = iss_pc;
                pred_d[tail_q]   = iss_pred_taken;
                target_d[tail_q] = iss_target;
                tail_d = tail_q + PTR_W'(1);
            end

            if (issue_ok && !retire)      count_d = count_q + TAG_W'(1);
            else if (!issue_ok && retire) count_d = count_q - TAG_W'(1);

            // Mispredict wipes every entry, including anything issued or completed this edge.
            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    busy_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;  ready_q[i] <= 1'b0;  pred_q[i] <= 1'b0;  type_q[i] <= 2'd0;
                rd_q[i] <= 5'd0;  pc_q[i] <= 32'h0;  target_q[i] <= 32'h0;  res_q[i] <= 32'h0;
            end
            head_q <= '0;  tail_q <= '0;  count_q <= '0;
            commit_valid_q <= 1'b0;  commit_rd_q <= 5'd0;  commit_val_q <= 32'h0;
            commit_tag_q <= '0;  st_commit_q <= 1'b0;  st_commit_tag_q <= '0;
            bp_update_q <= 1'b0;  bp_pc_q <= 32'h0;  bp_taken_q <= 1'b0;
            flush_q <= 1'b0;  flush_pc_q <= 32'h0;
        end else begin
            busy_q <= busy_d;  ready_q <= ready_d;  pred_q <= pred_d;  type_q <= type_d;
            rd_q <= rd_d;  pc_q <= pc_d;  target_q <= target_d;  res_q <= res_d;
            head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
            commit_valid_q <= commit_valid_d;  commit_rd_q <= commit_rd_d;
            commit_val_q <= commit_val_d;  commit_tag_q <= commit_tag_d;
            st_commit_q <= st_commit_d;  st_commit_tag_q <= st_commit_tag_d;
            bp_update_q <= bp_update_d;  bp_pc_q <= bp_pc_d;  bp_taken_q <= bp_taken_d;
            flush_q <= flush_d;  flush_pc_q <= flush_pc_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_rd     = commit_rd_q;
    assign commit_val    = commit_val_q;
    assign commit_tag    = commit_tag_q;
    assign st_commit     = st_commit_q;
    assign st_commit_tag = st_commit_tag_q;
    assign bp_update     = bp_update_q;
    assign bp_pc         = bp_pc_q;
    assign bp_taken      = bp_taken_q;
    assign flush_out     = flush_q;
    assign flush_pc      = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed bench for reorder_buffer_mp: vector table for fill/complete/commit/bypass,
// hand sequences for reset, mispredict flush, correct prediction, store release and freeze.
module tb_reorder_buffer_mp;
    localparam int DEPTH = 8;
    localparam int CP    = 2;
    localparam int TW    = 4;

    logic            clk = 1'b0;
    logic            rst_in, rdy_in;
    logic            iss_valid, iss_pred_taken;
    logic [1:0]      iss_type;
    logic [4:0]      iss_rd;
    logic [31:0]     iss_pc, iss_target;
    logic [TW-1:0]   iss_tag;
    logic            rob_full, rob_empty;
    logic [CP-1:0]   cdb_valid;
    logic [CP*TW-1:0] cdb_tag;
    logic [CP*32-1:0] cdb_val;
    logic [TW-1:0]   q_tag1, q_tag2;
    logic            q_rdy1, q_rdy2;
    logic [31:0]     q_val1, q_val2;
    logic            commit_valid, st_commit, bp_update, bp_taken, flush_out;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_val, bp_pc, flush_pc;
    logic [TW-1:0]   commit_tag, st_commit_tag;

    always #5 clk = ~clk;

    reorder_buffer_mp #(.DEPTH(DEPTH), .CDB_PORTS(CP)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .iss_valid(iss_valid), .iss_type(iss_type), .iss_rd(iss_rd), .iss_pc(iss_pc),
        .iss_pred_taken(iss_pred_taken), .iss_target(iss_target), .iss_tag(iss_tag),
        .rob_full(rob_full), .rob_empty(rob_empty),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .q_tag1(q_tag1), .q_tag2(q_tag2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
        .q_val1(q_val1), .q_val2(q_val2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_tag(commit_tag), .st_commit(st_commit), .st_commit_tag(st_commit_tag),
        .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .flush_out(flush_out), .flush_pc(flush_pc)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        iv;   logic [4:0]  ird;
        logic [1:0]  cv;   logic [3:0]  ct0;  logic [31:0] cd0;  logic [3:0] ct1;  logic [31:0] cd1;
        logic [3:0]  qt1;  logic [3:0]  qt2;
        logic        e_full;  logic e_empty;  logic [3:0] e_itag;
        logic        e_qr1;   logic [31:0] e_qv1;  logic e_qr2;  logic [31:0] e_qv2;
        logic        e_cv;    logic [4:0]  e_crd;  logic [31:0] e_cval;  logic [3:0] e_ctag;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input int iv, ird, cv, ct0, cd0, ct1, cd1, qt1, qt2,
                                input int full, empty, itag, qr1, qv1, qr2, qv2,
                                input int ecv, crd, cval, ctag);
        vec_t v;
        v.iv = 1'(iv);  v.ird = 5'(ird);  v.cv = 2'(cv);
        v.ct0 = 4'(ct0);  v.cd0 = 32'(cd0);  v.ct1 = 4'(ct1);  v.cd1 = 32'(cd1);
        v.qt1 = 4'(qt1);  v.qt2 = 4'(qt2);
        v.e_full = 1'(full);  v.e_empty = 1'(empty);  v.e_itag = 4'(itag);
        v.e_qr1 = 1'(qr1);  v.e_qv1 = 32'(qv1);  v.e_qr2 = 1'(qr2);  v.e_qv2 = 32'(qv2);
        v.e_cv = 1'(ecv);  v.e_crd = 5'(crd);  v.e_cval = 32'(cval);  v.e_ctag = 4'(ctag);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;  iss_type = 2'd0;  iss_rd = 5'd0;  iss_pc = 32'h0;
        iss_pred_taken = 1'b0;  iss_target = 32'h0;
        cdb_valid = '0;  cdb_tag = '0;  cdb_val = '0;
        q_tag1 = '0;  q_tag2 = '0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred, input logic [31:0] tgt);
        iss_valid = 1'b1;  iss_type = t;  iss_rd = rd;  iss_pc = pc;
        iss_pred_taken = pred;  iss_target = tgt;
    endtask

    task automatic cdb(input int port, input logic [TW-1:0] tag, input logic [31:0] val);
        cdb_valid[port]          = 1'b1;
        cdb_tag[port*TW +: TW]   = tag;
        cdb_val[port*32 +: 32]   = val;
    endtask

    initial begin
        // iv ird | cv ct0 cd0 ct1 cd1 | qt1 qt2 || full empty itag | qr1 qv1 qr2 qv2 | cv crd cval ctag
        tbl[0] = mk(0,0, 0,0,0,0,0, 0,0, 0,1,1, 1,0,1,0, 0,0,0,0);
        for (int i = 1; i <= 8; i++)
            tbl[i] = mk(1,i, 0,0,0,0,0, 0,0, 0,(i == 1),i, 1,0,1,0, 0,0,0,0);
        tbl[9]  = mk(1,9, 0,0,0,0,0,       0,0, 1,0,1, 1,0,1,0,     0,0,0,0);
        tbl[10] = mk(0,0, 2,0,0,3,'h33,    3,0, 1,0,1, 1,'h33,1,0,  0,0,0,0);
        tbl[11] = mk(0,0, 1,2,'h22,0,0,    0,0, 1,0,1, 1,0,1,0,     0,0,0,0);
        tbl[12] = mk(0,0, 2,0,0,1,'h11,    0,0, 1,0,1, 1,0,1,0,     0,0,0,0);
        tbl[13] = mk(0,0, 0,0,0,0,0,       3,4, 1,0,1, 1,'h33,0,0,  0,0,0,0);
        tbl[14] = mk(0,0, 3,4,'hA,4,'hB,   4,0, 0,0,1, 1,'hA,1,0,   1,1,'h11,1);
        tbl[15] = mk(0,0, 1,5,'h77,0,0,    5,0, 0,0,1, 1,'h77,1,0,  1,2,'h22,2);
        tbl[16] = mk(0,0, 0,0,0,0,0,       0,0, 0,0,1, 1,0,1,0,     1,3,'h33,3);
        tbl[17] = mk(0,0, 0,0,0,0,0,       0,0, 0,0,1, 1,0,1,0,     1,4,'hA,4);
        tbl[18] = mk(0,0, 0,0,0,0,0,       0,0, 0,0,1, 1,0,1,0,     1,5,'h77,5);
        tbl[19] = mk(0,0, 0,0,0,0,0,       0,0, 0,0,1, 1,0,1,0,     0,0,0,0);

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_in = 1'b0;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            idle_inputs();
            if (tbl[k].iv) issue(2'd0, tbl[k].ird, 32'h1000 + 32'(k * 4), 1'b0, 32'h0);
            if (tbl[k].cv[0]) cdb(0, tbl[k].ct0, tbl[k].cd0);
            if (tbl[k].cv[1]) cdb(1, tbl[k].ct1, tbl[k].cd1);
            q_tag1 = tbl[k].qt1;
            q_tag2 = tbl[k].qt2;
            #1;
            chk($sformatf("v%0d rob_full", k),     32'(rob_full),     32'(tbl[k].e_full));
            chk($sformatf("v%0d rob_empty", k),    32'(rob_empty),    32'(tbl[k].e_empty));
            chk($sformatf("v%0d iss_tag", k),      32'(iss_tag),      32'(tbl[k].e_itag));
            chk($sformatf("v%0d q_rdy1", k),       32'(q_rdy1),       32'(tbl[k].e_qr1));
            chk($sformatf("v%0d q_val1", k),       q_val1,            tbl[k].e_qv1);
            chk($sformatf("v%0d q_rdy2", k),       32'(q_rdy2),       32'(tbl[k].e_qr2));
            chk($sformatf("v%0d q_val2", k),       q_val2,            tbl[k].e_qv2);
            chk($sformatf("v%0d commit_valid", k), 32'(commit_valid), 32'(tbl[k].e_cv));
            chk($sformatf("v%0d flush_out", k),    32'(flush_out),    32'd0);
            if (tbl[k].e_cv) begin
                chk($sformatf("v%0d commit_rd", k),  32'(commit_rd),  32'(tbl[k].e_crd));
                chk($sformatf("v%0d commit_val", k), commit_val,      tbl[k].e_cval);
                chk($sformatf("v%0d commit_tag", k), 32'(commit_tag), 32'(tbl[k].e_ctag));
            end
        end

        // Mid-run reset with five busy entries (tags 6,7,8 left over, plus 1,2).
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd10, 32'h2000, 1'b0, 32'h0);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd11, 32'h2004, 1'b0, 32'h0);
        @(negedge clk); idle_inputs(); #1;
        chk("pre_rst rob_empty", 32'(rob_empty), 32'd0);
        chk("pre_rst iss_tag",   32'(iss_tag),   32'd3);
        #2 rst_in = 1'b1;
        #1;
        chk("rst rob_empty",    32'(rob_empty),    32'd1);
        chk("rst rob_full",     32'(rob_full),     32'd0);
        chk("rst iss_tag",      32'(iss_tag),      32'd1);
        chk("rst commit_valid", 32'(commit_valid), 32'd0);
        chk("rst st_commit",    32'(st_commit),    32'd0);
        chk("rst bp_update",    32'(bp_update),    32'd0);
        chk("rst flush_out",    32'(flush_out),    32'd0);
        @(negedge clk); rst_in = 1'b0;
        @(negedge clk); #1;
        chk("post_rst rob_empty", 32'(rob_empty), 32'd1);
        chk("post_rst iss_tag",   32'(iss_tag),   32'd1);

        // Mispredicted branch (predicted not-taken, resolves taken) with 3 younger entries.
        @(negedge clk); idle_inputs(); issue(2'd1, 5'd0, 32'h100, 1'b0, 32'h200);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd1, 32'h104, 1'b0, 32'h0);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd2, 32'h108, 1'b0, 32'h0);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd3, 32'h10C, 1'b0, 32'h0); cdb(0, 4'd1, 32'h1);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd20, 32'h110, 1'b0, 32'h0); cdb(1, 4'd2, 32'h5);
        #1;
        chk("br pre bp_update", 32'(bp_update), 32'd0);
        chk("br pre iss_tag",   32'(iss_tag),   32'd5);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd21, 32'h114, 1'b0, 32'h0); #1;
        chk("mp bp_update", 32'(bp_update), 32'd1);
        chk("mp bp_taken",  32'(bp_taken),  32'd1);
        chk("mp bp_pc",     bp_pc,          32'h100);
        chk("mp flush_out", 32'(flush_out), 32'd1);
        chk("mp flush_pc",  flush_pc,       32'h200);
        chk("mp rob_empty", 32'(rob_empty), 32'd1);
        chk("mp iss_tag",   32'(iss_tag),   32'd1);
        @(negedge clk); idle_inputs(); #1;
        chk("mp+1 rob_empty", 32'(rob_empty), 32'd1);
        chk("mp+1 iss_tag",   32'(iss_tag),   32'd1);
        chk("mp+1 flush_out", 32'(flush_out), 32'd0);
        chk("mp+1 bp_update", 32'(bp_update), 32'd0);

        // Correctly predicted not-taken branch, then a reg-write and a store; freeze before store.
        @(negedge clk); idle_inputs(); issue(2'd1, 5'd0, 32'h300, 1'b0, 32'h400);
        @(negedge clk); idle_inputs(); issue(2'd0, 5'd7, 32'h304, 1'b0, 32'h0); cdb(0, 4'd1, 32'h0);
        @(negedge clk); idle_inputs(); issue(2'd2, 5'd0, 32'h308, 1'b0, 32'h0); cdb(1, 4'd2, 32'h99);
        @(negedge clk); idle_inputs(); cdb(0, 4'd3, 32'h0); #1;
        chk("nt bp_update", 32'(bp_update), 32'd1);
        chk("nt bp_taken",  32'(bp_taken),  32'd0);
        chk("nt bp_pc",     bp_pc,          32'h300);
        chk("nt flush_out", 32'(flush_out), 32'd0);
        chk("nt rob_empty", 32'(rob_empty), 32'd0);
        chk("nt iss_tag",   32'(iss_tag),   32'd4);
        @(negedge clk); idle_inputs(); #1;
        chk("c7 commit_valid", 32'(commit_valid), 32'd1);
        chk("c7 commit_rd",    32'(commit_rd),    32'd7);
        chk("c7 commit_val",   commit_val,        32'h99);
        chk("c7 commit_tag",   32'(commit_tag),   32'd2);
        rdy_in = 1'b0;
        issue(2'd0, 5'd9, 32'h30C, 1'b0, 32'h0);
        @(negedge clk); idle_inputs(); #1;
        chk("frz commit_valid", 32'(commit_valid), 32'd0);
        chk("frz st_commit",    32'(st_commit),    32'd0);
        chk("frz rob_empty",    32'(rob_empty),    32'd0);
        chk("frz iss_tag",      32'(iss_tag),      32'd4);
        rdy_in = 1'b1;
        @(negedge clk); idle_inputs(); #1;
        chk("st st_commit",     32'(st_commit),     32'd1);
        chk("st st_commit_tag", 32'(st_commit_tag), 32'd3);
        chk("st commit_valid",  32'(commit_valid),  32'd0);
        chk("st rob_empty",     32'(rob_empty),     32'd1);
        chk("st iss_tag",       32'(iss_tag),       32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
